hazard_controller: RTL and testbench

//  Pipeline sequencing controller for the ID/EX boundary of the 5-stage RV32I core.
//  - Keeps a per-register ready-timer scoreboard of in-flight writes.
//  - Detects read-after-write hazards that forwarding cannot cover (load-use).
//  - Drives stall_if/stall_id/bubble_id/flush_if into the fetch and decode stages.
//  - Sequences control-flow redirects and external memory waits.

---
 rtl/hazard_controller_if.sv | 40 ++++
 rtl/hazard_controller.sv | 145 ++++++++++++++
 tb/tb_hazard_controller.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/hazard_controller_if.sv
`default_nettype none
// ============================================================================
// Module      : hazard_controller_if
// Description : ID-stage operand/issue information plus redirect and memory
//               wait inputs, and the stall/bubble/flush controls returned to
//               the fetch and decode stages.
// Revision    : 1.0 - initial release
// ============================================================================
interface hazard_controller_if;
    logic        id_valid;
    logic [4:0]  id_rs1_addr;
    logic        id_rs1_used;
    logic [4:0]  id_rs2_addr;
    logic        id_rs2_used;
    logic [4:0]  id_rd_addr;
    logic        id_wr_en;
    logic        id_is_load;
    logic        ex_redirect;
    logic        ext_stall;
    logic        stall_if;
    logic        stall_id;
    logic        bubble_id;
    logic        flush_if;
    logic [31:0] stall_count;

    // Pipeline side: supplies instruction info, consumes the controls
    modport master (
        output id_valid, id_rs1_addr, id_rs1_used, id_rs2_addr, id_rs2_used,
               id_rd_addr, id_wr_en, id_is_load, ex_redirect, ext_stall,
        input  stall_if, stall_id, bubble_id, flush_if, stall_count
    );

    // Controller side
    modport slave (
        input  id_valid, id_rs1_addr, id_rs1_used, id_rs2_addr, id_rs2_used,
               id_rd_addr, id_wr_en, id_is_load, ex_redirect, ext_stall,
        output stall_if, stall_id, bubble_id, flush_if, stall_count
    );
endinterface
`default_nettype wire

// File: rtl/hazard_controller.sv
`default_nettype none
// ============================================================================
// Module      : hazard_controller
// Description : ID/EX sequencing controller. Tracks in-flight register writes
//               with per-register ready timers, stalls load-use hazards,
//               inserts redirect bubbles and freezes on external memory waits.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_controller #(
    parameter int LOAD_LAT     = 1,
    parameter int ALU_LAT      = 0,
    parameter int FLUSH_CYCLES = 1
) (
    input  wire logic           clk,
    input  wire logic           rst,
    hazard_controller_if.slave  bus
);
    localparam int c_MAX_LAT = (LOAD_LAT > ALU_LAT) ? LOAD_LAT : ALU_LAT;
    // A zero-latency configuration would give a zero-width timer; keep one bit
    localparam int c_TW      = (c_MAX_LAT > 0) ? $clog2(c_MAX_LAT + 1) : 1;
    localparam int c_FW      = $clog2(FLUSH_CYCLES + 1);

    localparam logic [c_TW-1:0] c_LOAD_T      = c_TW'(LOAD_LAT);
    localparam logic [c_TW-1:0] c_ALU_T       = c_TW'(ALU_LAT);
    localparam logic [c_FW-1:0] c_FLUSH_RLD   = c_FW'(FLUSH_CYCLES - 1);
    localparam logic [31:0]     c_COUNT_MAX   = 32'hFFFF_FFFF;

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [c_FW-1:0]   r_flush_cnt;
    logic [c_FW-1:0]   w_flush_cnt_nxt;
    logic [c_TW-1:0]   r_timer [32];
    logic [31:0]       r_stall_count;

    logic              w_stall_if;
    logic              w_stall_id;
    logic              w_bubble_id;
    logic              w_flush_if;
    logic              w_hazard;
    logic              w_issue;
    logic [c_TW-1:0]   w_issue_lat;

    // Load-use hazard: a used, non-x0 source still has a pending ready timer
    always_comb begin
        w_hazard = bus.id_valid &
                   ((bus.id_rs1_used & (bus.id_rs1_addr != 5'd0) &
                     (r_timer[bus.id_rs1_addr] != '0)) |
                    (bus.id_rs2_used & (bus.id_rs2_addr != 5'd0) &
                     (r_timer[bus.id_rs2_addr] != '0)));
    end

    // Control outputs and FSM next state, by priority: ext_stall > redirect/flush > hazard
    always_comb begin
        w_stall_if      = 1'b0;
        w_stall_id      = 1'b0;
        w_bubble_id     = 1'b0;
        w_flush_if      = 1'b0;
        w_state_nxt     = r_state;
        w_flush_cnt_nxt = r_flush_cnt;
        if (!rst) begin
            if (bus.ext_stall) begin
                w_stall_if = 1'b1;
                w_stall_id = 1'b1;
            end else if (bus.ex_redirect) begin
                w_flush_if  = 1'b1;
                w_bubble_id = 1'b1;
                if (FLUSH_CYCLES > 1) begin
                    w_state_nxt     = ST_FLUSH;
                    w_flush_cnt_nxt = c_FLUSH_RLD;
                end else begin
                    w_state_nxt     = ST_RUN;
                    w_flush_cnt_nxt = '0;
                end
            end else if (r_state == ST_FLUSH) begin
                w_bubble_id     = 1'b1;
                w_flush_cnt_nxt = r_flush_cnt - 1'b1;
                if (r_flush_cnt == c_FW'(1)) begin
                    w_state_nxt = ST_RUN;
                end
            end else if (w_hazard) begin
                w_stall_if  = 1'b1;
                w_stall_id  = 1'b1;
                w_bubble_id = 1'b1;
            end
        end
    end

    // An instruction leaves ID into EX only when nothing holds or kills it
    always_comb begin
        w_issue     = bus.id_valid & ~w_stall_id & ~w_bubble_id & ~bus.ext_stall &
                      bus.id_wr_en & (bus.id_rd_addr != 5'd0);
        w_issue_lat = bus.id_is_load ? c_LOAD_T : c_ALU_T;
    end

    // FSM state and flush bubble counter; frozen during memory waits
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_RUN;
            r_flush_cnt <= '0;
        end else if (!bus.ext_stall) begin
            r_state     <= w_state_nxt;
            r_flush_cnt <= w_flush_cnt_nxt;
        end
    end

    // Ready-timer scoreboard: issue loads the latency, otherwise count down
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                r_timer[i] <= '0;
            end
        end else if (!bus.ext_stall) begin
            r_timer[0] <= '0;
            for (int i = 1; i < 32; i++) begin
                if (w_issue && (bus.id_rd_addr == 5'(i))) begin
                    r_timer[i] <= w_issue_lat;
                end else if (r_timer[i] != '0) begin
                    r_timer[i] <= r_timer[i] - 1'b1;
                end
            end
        end
    end

    // Saturating count of bubble cycles (hazard stalls and flush bubbles)
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_count <= '0;
        end else if (w_bubble_id && !bus.ext_stall && (r_stall_count != c_COUNT_MAX)) begin
            r_stall_count <= r_stall_count + 32'd1;
        end
    end

    assign bus.stall_if    = w_stall_if;
    assign bus.stall_id    = w_stall_id;
    assign bus.bubble_id   = w_bubble_id;
    assign bus.flush_if    = w_flush_if;
    assign bus.stall_count = r_stall_count;

endmodule
`default_nettype wire

// File: tb/tb_hazard_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_controller
// Description : Directed vector table plus randomized run against a
//               ready-time reference model for hazard_controller.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_controller;
    localparam int LOAD_LAT     = 1;
    localparam int ALU_LAT      = 0;
    localparam int FLUSH_CYCLES = 2;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    hazard_controller_if hif ();

    hazard_controller #(
        .LOAD_LAT    (LOAD_LAT),
        .ALU_LAT     (ALU_LAT),
        .FLUSH_CYCLES(FLUSH_CYCLES)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (hif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        v;
        logic [4:0]  rs1;
        logic        u1;
        logic [4:0]  rs2;
        logic        u2;
        logic [4:0]  rd;
        logic        we;
        logic        ld;
        logic        redir;
        logic        ext;
        logic [3:0]  exp;   // {stall_if, stall_id, bubble_id, flush_if}
        int unsigned cnt;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic r, logic v, logic [4:0] rs1, logic u1,
                                logic [4:0] rs2, logic u2, logic [4:0] rd,
                                logic we, logic ld, logic redir, logic ext,
                                logic [3:0] exp, int unsigned cnt);
        vec_t t;
        t.rst = r;  t.v = v;  t.rs1 = rs1; t.u1 = u1; t.rs2 = rs2; t.u2 = u2;
        t.rd = rd;  t.we = we; t.ld = ld;  t.redir = redir; t.ext = ext;
        t.exp = exp; t.cnt = cnt;
        return t;
    endfunction

    task automatic drive(input vec_t t);
        rst             = t.rst;
        hif.id_valid    = t.v;
        hif.id_rs1_addr = t.rs1;
        hif.id_rs1_used = t.u1;
        hif.id_rs2_addr = t.rs2;
        hif.id_rs2_used = t.u2;
        hif.id_rd_addr  = t.rd;
        hif.id_wr_en    = t.we;
        hif.id_is_load  = t.ld;
        hif.ex_redirect = t.redir;
        hif.ext_stall   = t.ext;
    endtask

    task automatic check(input string name, input logic [3:0] exp, input int unsigned cnt);
        logic [3:0] act;
        act = {hif.stall_if, hif.stall_id, hif.bubble_id, hif.flush_if};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s ctrl {sif,sid,bub,fl} got %b want %b", name, act, exp);
        end
        checks++;
        if (hif.stall_count !== cnt) begin
            errors++;
            $display("FAIL %s stall_count got %0d want %0d", name, hif.stall_count, cnt);
        end
    endtask

    // Reference model: absolute "ready at active cycle N" per register
    int          ready_at [32];
    int          active;
    int          flush_left;
    int unsigned model_cnt;

    function automatic logic [3:0] model_expect(input vec_t t);
        logic haz;
        if (t.rst)          return 4'b0000;
        if (t.ext)          return 4'b1100;
        if (t.redir)        return 4'b0011;
        if (flush_left > 0) return 4'b0010;
        haz = t.v && ((t.u1 && t.rs1 != 0 && ready_at[t.rs1] > active) ||
                      (t.u2 && t.rs2 != 0 && ready_at[t.rs2] > active));
        return haz ? 4'b1110 : 4'b0000;
    endfunction

    task automatic model_step(input vec_t t, input logic [3:0] e);
        if (t.rst) begin
            for (int r = 0; r < 32; r++) ready_at[r] = 0;
            active = 0; flush_left = 0; model_cnt = 0;
        end else if (!t.ext) begin
            if (e[1] && model_cnt != 32'hFFFF_FFFF) model_cnt++;
            if (t.redir)             flush_left = FLUSH_CYCLES - 1;
            else if (flush_left > 0) flush_left--;
            if (t.v && e == 4'b0000 && t.we && t.rd != 0)
                ready_at[t.rd] = active + 1 + (t.ld ? LOAD_LAT : ALU_LAT);
            active++;
        end
    endtask

    initial begin
        vec_t t;
        logic [3:0] e;
        checks = 0;
        errors = 0;

        //            rst v rs1 u1 rs2 u2 rd we ld rdr ext  exp     cnt
        tbl.push_back(mk(1,0, 0,0, 0,0, 0,0,0, 0,0, 4'b0000, 0)); // reset
        tbl.push_back(mk(1,1, 5,1, 0,0, 0,0,0, 1,0, 4'b0000, 0)); // rst masks redirect
        tbl.push_back(mk(0,1, 0,0, 0,0, 5,1,1, 0,0, 4'b0000, 0)); // lw x5
        tbl.push_back(mk(0,1, 5,1, 0,0, 6,1,0, 0,0, 4'b1110, 0)); // load-use
        tbl.push_back(mk(0,1, 5,1, 0,0, 6,1,0, 0,0, 4'b0000, 1)); // released, add x6
        tbl.push_back(mk(0,1, 0,0, 6,1, 0,0,0, 0,0, 4'b0000, 1)); // ALU forwarded
        tbl.push_back(mk(0,1, 0,0, 0,0, 0,1,1, 0,0, 4'b0000, 1)); // lw x0
        tbl.push_back(mk(0,1, 0,1, 0,0, 0,0,0, 0,0, 4'b0000, 1)); // read x0
        tbl.push_back(mk(0,1, 0,0, 0,0, 6,1,1, 0,0, 4'b0000, 1)); // lw x6
        tbl.push_back(mk(0,1, 1,1, 6,0, 0,0,0, 0,0, 4'b0000, 1)); // rs2 unused
        tbl.push_back(mk(0,1, 0,0, 0,0, 7,1,1, 1,0, 4'b0011, 1)); // redirect kills lw x7
        tbl.push_back(mk(0,0, 0,0, 0,0, 0,0,0, 0,0, 4'b0010, 2)); // flush bubble
        tbl.push_back(mk(0,1, 7,1, 0,0, 0,0,0, 0,0, 4'b0000, 3)); // x7 never set
        tbl.push_back(mk(0,1, 0,0, 0,0, 5,1,1, 0,0, 4'b0000, 3)); // lw x5
        tbl.push_back(mk(0,1, 5,1, 0,0, 0,0,0, 0,1, 4'b1100, 3)); // ext freeze
        tbl.push_back(mk(0,1, 5,1, 0,0, 0,0,0, 0,1, 4'b1100, 3));
        tbl.push_back(mk(0,1, 5,1, 0,0, 0,0,0, 0,1, 4'b1100, 3));
        tbl.push_back(mk(0,1, 5,1, 0,0, 0,0,0, 0,0, 4'b1110, 3)); // timer was held
        tbl.push_back(mk(0,1, 5,1, 0,0, 0,0,0, 0,0, 4'b0000, 4));
        tbl.push_back(mk(0,0, 0,0, 0,0, 0,0,0, 1,0, 4'b0011, 4)); // enter FLUSH
        tbl.push_back(mk(1,0, 0,0, 0,0, 0,0,0, 0,0, 4'b0000, 5)); // rst mid-flush
        tbl.push_back(mk(0,0, 0,0, 0,0, 0,0,0, 0,0, 4'b0000, 0)); // back in RUN
        tbl.push_back(mk(0,1, 0,0, 0,0, 5,1,1, 0,0, 4'b0000, 0)); // lw x5
        tbl.push_back(mk(0,1, 5,1, 0,0, 0,0,0, 0,0, 4'b1110, 0)); // hazard
        tbl.push_back(mk(1,1, 5,1, 0,0, 0,0,0, 0,0, 4'b0000, 1)); // rst mid-hazard
        tbl.push_back(mk(0,1, 5,1, 0,0, 0,0,0, 0,0, 4'b0000, 0)); // scoreboard empty
        tbl.push_back(mk(0,0, 0,0, 0,0, 0,0,0, 1,1, 4'b1100, 0)); // ext beats redirect
        tbl.push_back(mk(0,0, 0,0, 0,0, 0,0,0, 1,0, 4'b0011, 0)); // redirect
        tbl.push_back(mk(0,0, 0,0, 0,0, 0,0,0, 1,0, 4'b0011, 1)); // redirect in FLUSH reloads
        tbl.push_back(mk(0,0, 0,0, 0,0, 0,0,0, 0,0, 4'b0010, 2));
        tbl.push_back(mk(0,0, 0,0, 0,0, 0,0,0, 0,0, 4'b0000, 3));

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            drive(tbl[i]);
            #1;
            check($sformatf("vec%0d", i), tbl[i].exp, tbl[i].cnt);
        end

        // Randomized phase; first cycle is a reset to align the model
        for (int n = 0; n < 600; n++) begin
            @(negedge clk);
            t.rst   = (n == 0) || ($urandom_range(0, 99) < 2);
            t.v     = ($urandom_range(0, 9) < 8);
            t.rs1   = 5'($urandom_range(0, 3));
            t.u1    = $urandom_range(0, 1) == 1;
            t.rs2   = 5'($urandom_range(0, 3));
            t.u2    = $urandom_range(0, 1) == 1;
            t.rd    = 5'($urandom_range(0, 3));
            t.we    = ($urandom_range(0, 9) < 7);
            t.ld    = $urandom_range(0, 1) == 1;
            t.redir = ($urandom_range(0, 99) < 8);
            t.ext   = ($urandom_range(0, 99) < 12);
            drive(t);
            #1;
            e = model_expect(t);
            if (n > 0) check($sformatf("rnd%0d", n), e, model_cnt);
            @(posedge clk);
            model_step(t, e);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
